// File: rtl/sa_os_feeder.sv
// ============================================================================
// Module   : sa_os_feeder
// Purpose  : Skewing operand feeder and tile sequencer for an output-stationary
//            systolic array.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sa_os_feeder #(
  parameter int A_H    = 16,
  parameter int B_W    = 16,
  parameter int WIDTH  = 8,
  parameter int PE_LAT = 2,
  parameter int KCNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [A_H*WIDTH-1:0]   in_a,
  input  logic [B_W*WIDTH-1:0]   in_b,
  input  logic                   in_last,
  output logic [A_H*WIDTH-1:0]   A,
  output logic [B_W*WIDTH-1:0]   B,
  output logic                   clc,
  output logic                   done,
  output logic                   result_valid,
  output logic [KCNT_W-1:0]      tile_k
);

  // done is registered, so it is raised one edge before its cycle.
  localparam int c_drain_n = A_H + B_W + PE_LAT;
  localparam int c_dcnt_w  = (c_drain_n > 2) ? $clog2(c_drain_n - 1) : 1;
  localparam logic [c_dcnt_w-1:0] c_dcnt_last = c_dcnt_w'(c_drain_n - 2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_in_ready;
  logic [c_dcnt_w-1:0] r_dcnt;
  logic [KCNT_W-1:0]   r_kcnt;
  logic [KCNT_W-1:0]   r_tile_k;
  logic                r_clc;
  logic                r_done;
  logic                r_rv;

  logic w_accept;
  logic w_first;

  assign w_accept = in_valid & r_in_ready;
  assign w_first  = w_accept & (r_state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b1;
      r_dcnt     <= '0;
      r_kcnt     <= '0;
      r_tile_k   <= '0;
      r_clc      <= 1'b0;
      r_done     <= 1'b0;
      r_rv       <= 1'b0;
    end else begin
      r_clc  <= w_first;
      r_done <= 1'b0;
      if (w_first) begin
        r_rv <= 1'b0;
      end
      if (w_accept) begin
        if (w_first) begin
          r_kcnt <= KCNT_W'(1);
        end else if (!(&r_kcnt)) begin
          r_kcnt <= r_kcnt + 1'b1;
        end
      end
      case (r_state)
        S_IDLE, S_STREAM: begin
          if (w_accept) begin
            if (in_last) begin
              r_state    <= S_DRAIN;
              r_in_ready <= 1'b0;
              r_dcnt     <= '0;
            end else begin
              r_state <= S_STREAM;
            end
          end
        end
        S_DRAIN: begin
          if (r_dcnt == c_dcnt_last) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
            r_done     <= 1'b1;
            r_rv       <= 1'b1;
            r_tile_k   <= r_kcnt;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign clc          = r_clc;
  assign done         = r_done;
  assign result_valid = r_rv;
  assign tile_k       = r_tile_k;

  // Lane i is delayed by 1+i stages; non-accept cycles inject zero bubbles.
  for (genvar i = 0; i < A_H; i++) begin : g_a_lane
    logic [WIDTH-1:0] r_sr [0:i];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k <= i; k++) r_sr[k] <= '0;
      end else begin
        r_sr[0] <= w_accept ? in_a[WIDTH*i +: WIDTH] : '0;
        for (int k = 1; k <= i; k++) r_sr[k] <= r_sr[k-1];
      end
    end
    assign A[WIDTH*i +: WIDTH] = r_sr[i];
  end

  for (genvar j = 0; j < B_W; j++) begin : g_b_lane
    logic [WIDTH-1:0] r_sr [0:j];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k <= j; k++) r_sr[k] <= '0;
      end else begin
        r_sr[0] <= w_accept ? in_b[WIDTH*j +: WIDTH] : '0;
        for (int k = 1; k <= j; k++) r_sr[k] <= r_sr[k-1];
      end
    end
    assign B[WIDTH*j +: WIDTH] = r_sr[j];
  end

endmodule

`default_nettype wire
